// File: rtl/motor_position_ctrl.sv
// Proportional position loop for one motor axis: samples the decoder count at a fixed
// tick rate and drives a saturated PWM compare value plus direction toward the target.
module motor_position_ctrl #(
    parameter int unsigned TICK_DIV     = 120_000,
    parameter int unsigned COMPARE_MAX  = 60_000_000,
    parameter int unsigned DEADBAND     = 4,
    parameter int unsigned SETTLE_TICKS = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_target,
    input  logic [15:0] cmd_kp,
    input  logic [31:0] position,
    output logic [31:0] compare,
    output logic        dir,
    output logic        busy,
    output logic        settled
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = $clog2(SETTLE_TICKS + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_ERR,
        ST_MUL,
        ST_OUT
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [31:0]     target_q, target_d;
    logic [15:0]     kp_q, kp_d;
    logic [31:0]     sample_q, sample_d;
    logic [31:0]     abs_err_q, abs_err_d;
    logic            dir_next_q, dir_next_d;
    logic [39:0]     duty_q, duty_d;
    logic [31:0]     compare_q, compare_d;
    logic            dir_q, dir_d;
    logic            busy_q, busy_d;
    logic            settled_q, settled_d;
    logic [SW-1:0]   settle_cnt_q, settle_cnt_d;

    logic            tick;
    logic            accept;
    logic [32:0]     err;
    logic [32:0]     err_mag;
    logic [47:0]     prod;
    logic [31:0]     duty_sat;
    logic            in_band;
    logic [SW-1:0]   settle_inc;

    assign tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
    assign accept     = cmd_valid && enable;
    assign cmd_ready  = enable;

    // 33-bit signed error so extreme target/position pairs cannot wrap
    assign err        = {target_q[31], target_q} - {sample_q[31], sample_q};
    assign err_mag    = err[32] ? (33'd0 - err) : err;
    assign prod       = {16'd0, abs_err_q} * {32'd0, kp_q};
    assign duty_sat   = (duty_q > 40'(COMPARE_MAX)) ? 32'(COMPARE_MAX) : duty_q[31:0];
    assign in_band    = (abs_err_q <= 32'(DEADBAND));
    assign settle_inc = (settle_cnt_q < SW'(SETTLE_TICKS)) ? settle_cnt_q + SW'(1) : settle_cnt_q;

    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick ? '0 : tick_cnt_q + TW'(1);
        target_d     = target_q;
        kp_d         = kp_q;
        sample_d     = sample_q;
        abs_err_d    = abs_err_q;
        dir_next_d   = dir_next_q;
        duty_d       = duty_q;
        compare_d    = compare_q;
        dir_d        = dir_q;
        busy_d       = busy_q;
        settled_d    = settled_q;
        settle_cnt_d = settle_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                compare_d = '0;
                // A command arriving on the tick cycle is sampled by that same tick
                if (accept) begin
                    if (tick) begin
                        sample_d = position;
                        state_d  = ST_ERR;
                    end else begin
                        state_d  = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (tick) begin
                    sample_d = position;
                    state_d  = ST_ERR;
                end
            end
            ST_ERR: begin
                abs_err_d  = err_mag[32] ? '1 : err_mag[31:0];
                dir_next_d = err[32];
                state_d    = ST_MUL;
            end
            ST_MUL: begin
                duty_d  = 40'(prod >> 8);
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (in_band) begin
                    compare_d    = '0;
                    settle_cnt_d = settle_inc;
                    if (settle_inc == SW'(SETTLE_TICKS)) begin
                        settled_d = 1'b1;
                        busy_d    = 1'b0;
                    end
                end else begin
                    compare_d    = duty_sat;
                    dir_d        = dir_next_q;
                    settle_cnt_d = '0;
                    settled_d    = 1'b0;
                    busy_d       = 1'b1;
                end
                state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            target_d     = cmd_target;
            kp_d         = cmd_kp;
            settle_cnt_d = '0;
            settled_d    = 1'b0;
            busy_d       = 1'b1;
        end

        // Disable abandons any in-flight computation but keeps target and gain
        if (!enable) begin
            state_d      = ST_IDLE;
            compare_d    = '0;
            busy_d       = 1'b0;
            settled_d    = 1'b0;
            settle_cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            tick_cnt_q   <= '0;
            target_q     <= '0;
            kp_q         <= '0;
            sample_q     <= '0;
            abs_err_q    <= '0;
            dir_next_q   <= 1'b0;
            duty_q       <= '0;
            compare_q    <= '0;
            dir_q        <= 1'b0;
            busy_q       <= 1'b0;
            settled_q    <= 1'b0;
            settle_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            target_q     <= target_d;
            kp_q         <= kp_d;
            sample_q     <= sample_d;
            abs_err_q    <= abs_err_d;
            dir_next_q   <= dir_next_d;
            duty_q       <= duty_d;
            compare_q    <= compare_d;
            dir_q        <= dir_d;
            busy_q       <= busy_d;
            settled_q    <= settled_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

    assign compare = compare_q;
    assign dir     = dir_q;
    assign busy    = busy_q;
    assign settled = settled_q;

endmodule
